// File: rtl/alu_decode_cond_unit_pkg.sv
// Shared definitions for the ID/EX control slice: ALU operation codes,
// ARM data-processing opcodes, condition codes, shifter addressing modes,
// instruction class codes and the condition evaluation helper.
package alu_decode_cond_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_ADC  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SBC  = 4'b0011,
    ALU_RSB  = 4'b0100,
    ALU_RSC  = 4'b0101,
    ALU_AND  = 4'b0110,
    ALU_ORR  = 4'b0111,
    ALU_EOR  = 4'b1000,
    ALU_PASA = 4'b1001,
    ALU_PASB = 4'b1010,
    ALU_MVNB = 4'b1011,
    ALU_BIC  = 4'b1100
  } alu_op_e;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
    OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
    OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
    OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
  } arm_opcode_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    AM_ROT_IMM   = 2'b00,
    AM_REG_OFF   = 2'b01,
    AM_IMM12_OFF = 2'b10,
    AM_SHIFT_IMM = 2'b11
  } am_e;

  localparam logic [2:0] CLS_DP_SHIFT = 3'b000;
  localparam logic [2:0] CLS_DP_IMM   = 3'b001;
  localparam logic [2:0] CLS_LS_IMM   = 3'b010;
  localparam logic [2:0] CLS_LS_REG   = 3'b011;
  localparam logic [2:0] CLS_BRANCH   = 3'b101;

  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic n, input logic z,
                                     input logic c, input logic v);
    logic r_pass;
    case (cond)
      COND_EQ: r_pass = z;
      COND_NE: r_pass = ~z;
      COND_CS: r_pass = c;
      COND_CC: r_pass = ~c;
      COND_MI: r_pass = n;
      COND_PL: r_pass = ~n;
      COND_VS: r_pass = v;
      COND_VC: r_pass = ~v;
      COND_HI: r_pass = c & ~z;
      COND_LS: r_pass = ~c | z;
      COND_GE: r_pass = (n == v);
      COND_LT: r_pass = (n != v);
      COND_GT: r_pass = ~z & (n == v);
      COND_LE: r_pass = z | (n != v);
      COND_AL: r_pass = 1'b1;
      default: r_pass = 1'b0;
    endcase
    return r_pass;
  endfunction

endpackage

// File: rtl/alu_decode_cond_unit_alu_core.sv
// 32-bit ALU with N/Z/C/V generation.
// Ports: i_op (ALU operation), i_a/i_b (operands), i_cin (carry-in),
//        o_result, o_n/o_z/o_c/o_v (result flags).
module alu_core
  import alu_decode_cond_unit_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_result,
  output logic        o_n,
  output logic        o_z,
  output logic        o_c,
  output logic        o_v
);

  logic [31:0] w_opa;
  logic [31:0] w_opb;
  logic        w_cin;
  logic        w_arith;
  logic [32:0] w_sum;

  // All six arithmetic ops share one adder; subtracts feed an inverted operand.
  always_comb begin
    w_opa   = i_a;
    w_opb   = i_b;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    case (i_op)
      ALU_ADD: ;
      ALU_ADC: w_cin = i_cin;
      ALU_SUB: begin w_opb = ~i_b; w_cin = 1'b1;  end
      ALU_SBC: begin w_opb = ~i_b; w_cin = i_cin; end
      ALU_RSB: begin w_opa = i_b; w_opb = ~i_a; w_cin = 1'b1;  end
      ALU_RSC: begin w_opa = i_b; w_opb = ~i_a; w_cin = i_cin; end
      default: w_arith = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_opa} + {1'b0, w_opb} + {32'd0, w_cin};

  always_comb begin
    o_result = 32'd0;
    case (i_op)
      ALU_AND:  o_result = i_a & i_b;
      ALU_ORR:  o_result = i_a | i_b;
      ALU_EOR:  o_result = i_a ^ i_b;
      ALU_PASA: o_result = i_a;
      ALU_PASB: o_result = i_b;
      ALU_MVNB: o_result = ~i_b;
      ALU_BIC:  o_result = i_a & ~i_b;
      default:  if (w_arith) o_result = w_sum[31:0];
    endcase
  end

  assign o_n = o_result[31];
  assign o_z = (o_result == 32'd0);
  assign o_c = w_arith ? w_sum[32] : i_cin;
  assign o_v = w_arith & (w_opa[31] == w_opb[31]) & (o_result[31] != w_opa[31]);

endmodule

// File: rtl/alu_decode_cond_unit.sv
// ID/EX control slice: instruction decoder, EX-stage ALU, condition handler
// and the N/Z/C/V flag register.
// Ports: clk/reset (flag register only), instr (ID instruction) -> decoded
//        controls alu_op, id_am, id_load, id_mem_write, id_mem_size, id_mem_e,
//        store_cc, rf_e, id_b, id_bl; ex_alu_op/ex_a/ex_b/ex_store_cc (EX
//        stage) -> alu_result, alu_n/z/c/v; flag_n/z/c/v (register);
//        branch, branch_link, nop_ex (condition decisions).
module alu_decode_cond_unit
  import alu_decode_cond_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic [1:0]  id_am,
  output logic        id_load,
  output logic        id_mem_write,
  output logic        id_mem_size,
  output logic        id_mem_e,
  output logic        store_cc,
  output logic        rf_e,
  output logic        id_b,
  output logic        id_bl,
  input  logic [3:0]  ex_alu_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        ex_store_cc,
  output logic [31:0] alu_result,
  output logic        alu_n,
  output logic        alu_z,
  output logic        alu_c,
  output logic        alu_v,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v,
  output logic        branch,
  output logic        branch_link,
  output logic        nop_ex
);

  logic [3:0] r_flags;
  logic       w_cond;
  logic [2:0] w_cls;
  logic       w_test_op;
  logic       w_unused_instr;

  assign w_cls          = instr[27:25];
  assign w_unused_instr = ^instr[19:0];
  assign w_test_op      = (instr[24:21] == OP_TST) || (instr[24:21] == OP_TEQ) ||
                          (instr[24:21] == OP_CMP) || (instr[24:21] == OP_CMN);

  always_comb begin
    alu_op       = 4'd0;
    id_am        = 2'd0;
    id_load      = 1'b0;
    id_mem_write = 1'b0;
    id_mem_size  = 1'b0;
    id_mem_e     = 1'b0;
    store_cc     = 1'b0;
    rf_e         = 1'b0;
    id_b         = 1'b0;
    id_bl        = 1'b0;
    if (instr != 32'd0) begin
      case (w_cls)
        CLS_DP_SHIFT, CLS_DP_IMM: begin
          case (instr[24:21])
            OP_AND, OP_TST: alu_op = ALU_AND;
            OP_EOR, OP_TEQ: alu_op = ALU_EOR;
            OP_SUB, OP_CMP: alu_op = ALU_SUB;
            OP_ADD, OP_CMN: alu_op = ALU_ADD;
            OP_RSB:         alu_op = ALU_RSB;
            OP_ADC:         alu_op = ALU_ADC;
            OP_SBC:         alu_op = ALU_SBC;
            OP_RSC:         alu_op = ALU_RSC;
            OP_ORR:         alu_op = ALU_ORR;
            OP_MOV:         alu_op = ALU_PASB;
            OP_BIC:         alu_op = ALU_BIC;
            default:        alu_op = ALU_MVNB;
          endcase
          id_am    = (w_cls == CLS_DP_IMM) ? AM_ROT_IMM : AM_SHIFT_IMM;
          store_cc = instr[20] | w_test_op;
          rf_e     = ~w_test_op;
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          alu_op       = instr[23] ? ALU_ADD : ALU_SUB;
          id_am        = (w_cls == CLS_LS_IMM) ? AM_IMM12_OFF : AM_REG_OFF;
          id_mem_e     = 1'b1;
          id_load      = instr[20];
          id_mem_write = ~instr[20];
          rf_e         = instr[20];
          id_mem_size  = instr[22];
        end
        CLS_BRANCH: begin
          id_b  = ~instr[24];
          id_bl = instr[24];
        end
        default: ;
      endcase
    end
  end

  alu_core u_alu_core (
    .i_op     (ex_alu_op),
    .i_a      (ex_a),
    .i_b      (ex_b),
    .i_cin    (flag_c),
    .o_result (alu_result),
    .o_n      (alu_n),
    .o_z      (alu_z),
    .o_c      (alu_c),
    .o_v      (alu_v)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_flags <= 4'd0;
    else if (ex_store_cc) r_flags <= {alu_n, alu_z, alu_c, alu_v};
  end

  assign {flag_n, flag_z, flag_c, flag_v} = r_flags;

  // A flag-setting EX instruction forwards its flags to the ID condition.
  assign w_cond = ex_store_cc ? cond_pass(instr[31:28], alu_n, alu_z, alu_c, alu_v)
                              : cond_pass(instr[31:28], flag_n, flag_z, flag_c, flag_v);

  assign branch      = id_b & w_cond;
  assign branch_link = id_bl & w_cond;
  assign nop_ex      = (instr != 32'd0) & ~w_cond;

endmodule

// File: tb/tb_alu_decode_cond_unit.sv
module tb_alu_decode_cond_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic [3:0]  alu_op;
  logic [1:0]  id_am;
  logic        id_load, id_mem_write, id_mem_size, id_mem_e, store_cc, rf_e, id_b, id_bl;
  logic [3:0]  ex_alu_op = 4'd0;
  logic [31:0] ex_a = 32'd0, ex_b = 32'd0;
  logic        ex_store_cc = 1'b0;
  logic [31:0] alu_result;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        branch, branch_link, nop_ex;

  alu_decode_cond_unit dut (
    .clk(clk), .reset(reset), .instr(instr),
    .alu_op(alu_op), .id_am(id_am), .id_load(id_load), .id_mem_write(id_mem_write),
    .id_mem_size(id_mem_size), .id_mem_e(id_mem_e), .store_cc(store_cc), .rf_e(rf_e),
    .id_b(id_b), .id_bl(id_bl),
    .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b), .ex_store_cc(ex_store_cc),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .branch(branch), .branch_link(branch_link), .nop_ex(nop_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        scc;
  } stim_t;

  typedef struct {
    int          idx;
    logic [3:0]  alu_op;
    logic [1:0]  am;
    logic        load, mw, size, me, scc, rfe, b, bl;
    logic [31:0] res;
    logic [3:0]  aflags;   // {N,Z,C,V}
    logic [3:0]  rflags;
    logic        br, brl, nop;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_item = 0;
  logic [3:0] m_flags = 4'd0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s item %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Reference model --------------------------------------------------------
  function automatic logic [3:0] dp_alu_op(input logic [3:0] opc);
    logic [3:0] tbl [16] = '{4'b0110, 4'b1000, 4'b0010, 4'b0100, 4'b0000, 4'b0001,
                             4'b0011, 4'b0101, 4'b0110, 4'b1000, 4'b0010, 4'b0000,
                             4'b0111, 4'b1010, 4'b1100, 4'b1011};
    return tbl[opc];
  endfunction

  function automatic logic holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0: return z == 1;          1: return z == 0;
      2: return c == 1;          3: return c == 0;
      4: return n == 1;          5: return n == 0;
      6: return v == 1;          7: return v == 0;
      8: return c && !z;         9: return !c || z;
      10: return n == v;         11: return n != v;
      12: return !z && n == v;   13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Arithmetic evaluated as integer sums/differences; carry and overflow come
  // from range checks on the wide results.
  function automatic void alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, output logic [31:0] res, output logic [3:0] fl);
    longint ua, ub, sa, sb, u, s, ci;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); ci = cin;
    c = cin; v = 1'b0; res = 32'd0;
    case (op)
      0, 1: begin
        if (op == 0) ci = 0;
        u = ua + ub + ci; s = sa + sb + ci;
        c = (u >= 64'sd4294967296);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        res = u[31:0];
      end
      2, 3, 4, 5: begin
        if (op == 2 || op == 4) ci = 1;
        if (op <= 3) begin u = ua - ub - 1 + ci; s = sa - sb - 1 + ci; end
        else         begin u = ub - ua - 1 + ci; s = sb - sa - 1 + ci; end
        c = (u >= 0);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        res = u[31:0];
      end
      6:  res = a & b;
      7:  res = a | b;
      8:  res = a ^ b;
      9:  res = a;
      10: res = b;
      11: res = ~b;
      12: res = a & ~b;
      default: res = 32'd0;
    endcase
    fl = {res[31], res == 32'd0, c, v};
  endfunction

  function automatic exp_t model(input stim_t s, input logic [3:0] regf);
    exp_t e;
    logic [2:0] cls;
    logic [3:0] cf;
    logic cond;
    e = '{default: '0};
    cls = s.ins[27:25];
    if (s.ins != 0) begin
      if (cls == 0 || cls == 1) begin
        logic is_test;
        is_test = (s.ins[24:21] >= 8 && s.ins[24:21] <= 11);
        e.alu_op = dp_alu_op(s.ins[24:21]);
        e.am = (cls == 1) ? 2'b00 : 2'b11;
        e.scc = s.ins[20] || is_test;
        e.rfe = !is_test;
      end else if (cls == 2 || cls == 3) begin
        e.alu_op = s.ins[23] ? 4'b0000 : 4'b0010;
        e.am = (cls == 2) ? 2'b10 : 2'b01;
        e.me = 1; e.load = s.ins[20]; e.mw = !s.ins[20]; e.rfe = s.ins[20];
        e.size = s.ins[22];
      end else if (cls == 5) begin
        e.b = !s.ins[24]; e.bl = s.ins[24];
      end
    end
    alu_model(s.op, s.a, s.b, regf[1], e.res, e.aflags);
    e.rflags = regf;
    cf = s.scc ? e.aflags : regf;
    cond = holds(s.ins[31:28], cf);
    e.br = e.b && cond;
    e.brl = e.bl && cond;
    e.nop = (s.ins != 0) && !cond;
    return e;
  endfunction

  // Stimulus ---------------------------------------------------------------
  stim_t prev;
  exp_t  prev_e;
  bit    have_prev = 0;

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    if (have_prev && prev.scc && !prev.rst) m_flags = prev_e.aflags;
    #1;
    reset = s.rst; instr = s.ins; ex_alu_op = s.op; ex_a = s.a; ex_b = s.b; ex_store_cc = s.scc;
    if (s.rst) m_flags = 4'd0;
    e = model(s, m_flags);
    e.idx = n_item++;
    q.push_back(e);
    prev = s; prev_e = e; have_prev = 1;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  function automatic logic [31:0] pick_instr();
    logic [31:0] w;
    if ($urandom_range(0, 19) == 0) return 32'd0;
    w = $urandom;
    w[27:25] = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
    return w;
  endfunction

  // Monitor ----------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alu_op", e.idx, 32'(alu_op), 32'(e.alu_op));
        chk("id_am", e.idx, 32'(id_am), 32'(e.am));
        chk("mem_ctl", e.idx, {28'd0, id_load, id_mem_write, id_mem_size, id_mem_e},
            {28'd0, e.load, e.mw, e.size, e.me});
        chk("store_cc_rf_e", e.idx, {30'd0, store_cc, rf_e}, {30'd0, e.scc, e.rfe});
        chk("id_b_bl", e.idx, {30'd0, id_b, id_bl}, {30'd0, e.b, e.bl});
        chk("alu_result", e.idx, alu_result, e.res);
        chk("alu_nzcv", e.idx, {28'd0, alu_n, alu_z, alu_c, alu_v}, {28'd0, e.aflags});
        chk("flag_nzcv", e.idx, {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, e.rflags});
        chk("branch", e.idx, {29'd0, branch, branch_link, nop_ex}, {29'd0, e.br, e.brl, e.nop});
      end
    end
  end

  initial begin
    stim_t dir [9] = '{
      '{1'b1, 32'hE083_3002, 4'b0000, 32'd0, 32'd0, 1'b0},
      '{1'b0, 32'h0000_0000, 4'b0010, 32'd5, 32'd5, 1'b1},
      '{1'b0, 32'h0A00_0004, 4'b0000, 32'h7FFF_FFFF, 32'd1, 1'b0},
      '{1'b0, 32'h0000_0000, 4'b0000, 32'h7FFF_FFFF, 32'd1, 1'b1},
      '{1'b0, 32'h0A00_0004, 4'b1001, 32'd1, 32'd2, 1'b0},
      '{1'b0, 32'hE5D1_2004, 4'b0000, 32'd100, 32'd4, 1'b0},
      '{1'b0, 32'h0B00_0002, 4'b0010, 32'd3, 32'd3, 1'b1},
      '{1'b1, 32'hE0833002, 4'b0010, 32'd5, 32'd5, 1'b1},
      '{1'b0, 32'h0A00_0004, 4'b0001, 32'hFFFF_FFFF, 32'd1, 1'b0}
    };
    stim_t s;
    int wait_cnt;
    foreach (dir[i]) apply(dir[i]);
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 49) == 0);
      s.ins = pick_instr();
      s.op  = 4'($urandom_range(0, 15));
      s.a   = pick_operand();
      s.b   = pick_operand();
      s.scc = $urandom_range(0, 1) == 1;
      apply(s);
    end
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
